asic_output_classifier: RTL

ASIC_OUTPUT_CLASSIFIER -- requirements
Module: asic_output_classifier

---
 rtl/neuro_bridge_pkg.sv | 13 +
 rtl/aux_argmax_scan.sv | 57 +++++
 rtl/asic_output_classifier.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/neuro_bridge_pkg.sv
// Shared definitions for the aux-channel output classifier: FSM encoding,
// channel count and XADC sample width.
package neuro_bridge_pkg;
  localparam int NUM_CHAN = 4;
  localparam int CHAN_W   = 2;
  localparam int SAMPLE_W = 12;

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_COMPARE = 2'd1,
    ST_PUBLISH = 2'd2
  } state_e;
endpackage

// File: rtl/aux_argmax_scan.sv
// Serial max / runner-up tracker fed one channel sum per cycle. The *_o
// outputs are the post-update values so the caller can use the last step.
module aux_argmax_scan
  import neuro_bridge_pkg::*;
#(
  parameter int SUM_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              scan_valid_i,
  input  logic              scan_first_i,
  input  logic [CHAN_W-1:0] scan_chan_i,
  input  logic [SUM_W-1:0]  scan_sum_i,
  output logic [CHAN_W-1:0] max_idx_o,
  output logic [SUM_W-1:0]  max_sum_o,
  output logic [SUM_W-1:0]  runner_sum_o
);
  logic [CHAN_W-1:0] best_idx_q, best_idx_d;
  logic [SUM_W-1:0]  best_q, best_d;
  logic [SUM_W-1:0]  second_q, second_d;

  // Strict greater-than keeps the lower channel index on ties.
  always_comb begin
    best_idx_d = best_idx_q;
    best_d     = best_q;
    second_d   = second_q;
    if (scan_valid_i) begin
      if (scan_first_i) begin
        best_idx_d = scan_chan_i;
        best_d     = scan_sum_i;
        second_d   = '0;
      end else if (scan_sum_i > best_q) begin
        second_d   = best_q;
        best_d     = scan_sum_i;
        best_idx_d = scan_chan_i;
      end else if (scan_sum_i > second_q) begin
        second_d   = scan_sum_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      best_idx_q <= '0;
      best_q     <= '0;
      second_q   <= '0;
    end else begin
      best_idx_q <= best_idx_d;
      best_q     <= best_d;
      second_q   <= second_d;
    end
  end

  assign max_idx_o    = best_idx_d;
  assign max_sum_o    = best_d;
  assign runner_sum_o = second_d;
endmodule

// File: rtl/asic_output_classifier.sv
// Accumulates one sample per aux channel per round over a window of rounds,
// then picks the winning channel with a margin test and a stability count.
module asic_output_classifier
  import neuro_bridge_pkg::*;
#(
  parameter int WINDOW_LOG2  = 4,
  parameter int MIN_MARGIN   = 64,
  parameter int STABLE_COUNT = 3
) (
  input  logic                        S_AXI_ACLK,
  input  logic                        S_AXI_ARESETN,
  input  logic                        enable,
  input  logic                        clear,
  input  logic                        sample_valid,
  input  logic [1:0]                  sample_chan,
  input  logic [11:0]                 sample_data,
  output logic [1:0]                  network_output,
  output logic                        result_valid,
  output logic                        result_ambiguous,
  output logic                        result_stable,
  output logic [12+WINDOW_LOG2-1:0]   winner_sum,
  output logic                        seq_error,
  output logic                        drop_error
);
  localparam int AW = SAMPLE_W + WINDOW_LOG2;
  localparam int SW = $clog2(STABLE_COUNT + 1);
  localparam logic [AW-1:0] MARGIN = AW'(MIN_MARGIN);

  state_e                state_q, state_d;
  logic [AW-1:0]         acc_q [NUM_CHAN];
  logic [NUM_CHAN-1:0]   seen_q;
  logic [WINDOW_LOG2-1:0] round_q;
  logic [CHAN_W-1:0]     scan_q;
  logic [1:0]            net_q;
  logic                  valid_q, amb_q, seq_err_q, drop_err_q;
  logic [AW-1:0]         wsum_q;
  logic [SW-1:0]         stable_q;

  logic                  in_accum, take, accept, round_done, window_done, scan_last;
  logic [NUM_CHAN-1:0]   chan_bit, add_en;
  logic [CHAN_W-1:0]     max_idx;
  logic [AW-1:0]         max_sum, runner_sum, margin;
  logic                  margin_ok;

  assign in_accum    = (state_q == ST_ACCUM);
  assign take        = enable && sample_valid && in_accum && !clear;
  assign chan_bit    = NUM_CHAN'(1) << sample_chan;
  assign accept      = take && ((seen_q & chan_bit) == '0);
  assign round_done  = accept && ((seen_q | chan_bit) == '1);
  assign window_done = round_done && (round_q == '1);
  assign scan_last   = (state_q == ST_COMPARE) && (scan_q == CHAN_W'(NUM_CHAN - 1));

  for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_add
    assign add_en[gi] = accept && (sample_chan == CHAN_W'(gi));
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_ACCUM;
    end else begin
      case (state_q)
        ST_ACCUM:   if (window_done) state_d = ST_COMPARE;
        ST_COMPARE: if (scan_last)   state_d = ST_PUBLISH;
        default:                     state_d = ST_ACCUM;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) state_q <= ST_ACCUM;
    else                state_q <= state_d;
  end

  aux_argmax_scan #(.SUM_W(AW)) u_scan (
    .clk_i        (S_AXI_ACLK),
    .rst_ni       (S_AXI_ARESETN),
    .scan_valid_i (state_q == ST_COMPARE),
    .scan_first_i (scan_q == '0),
    .scan_chan_i  (scan_q),
    .scan_sum_i   (acc_q[scan_q]),
    .max_idx_o    (max_idx),
    .max_sum_o    (max_sum),
    .runner_sum_o (runner_sum)
  );

  assign margin    = max_sum - runner_sum;
  assign margin_ok = (margin >= MARGIN);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < NUM_CHAN; i++) acc_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CHAN; i++) begin
        if (clear || state_q == ST_PUBLISH) acc_q[i] <= '0;
        else if (add_en[i])                 acc_q[i] <= acc_q[i] + AW'(sample_data);
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      seen_q     <= '0;
      round_q    <= '0;
      scan_q     <= '0;
      net_q      <= '0;
      valid_q    <= 1'b0;
      amb_q      <= 1'b0;
      wsum_q     <= '0;
      stable_q   <= '0;
      seq_err_q  <= 1'b0;
      drop_err_q <= 1'b0;
    end else if (clear) begin
      // network_output and winner_sum deliberately survive a clear.
      seen_q     <= '0;
      round_q    <= '0;
      scan_q     <= '0;
      valid_q    <= 1'b0;
      amb_q      <= 1'b0;
      stable_q   <= '0;
      seq_err_q  <= 1'b0;
      drop_err_q <= 1'b0;
    end else begin
      valid_q <= scan_last;
      amb_q   <= scan_last && !margin_ok;
      scan_q  <= (state_q == ST_COMPARE) ? scan_q + 1'b1 : '0;
      if (state_q == ST_PUBLISH) begin
        seen_q  <= '0;
        round_q <= '0;
      end else if (accept) begin
        if (round_done) begin
          seen_q  <= '0;
          round_q <= round_q + 1'b1;
        end else begin
          seen_q  <= seen_q | chan_bit;
        end
      end
      if (take && !accept) seq_err_q <= 1'b1;
      if (enable && sample_valid && !in_accum) drop_err_q <= 1'b1;
      if (scan_last) begin
        wsum_q <= max_sum;
        if (margin_ok) begin
          net_q <= max_idx;
          if (max_idx != net_q)                     stable_q <= SW'(1);
          else if (stable_q != SW'(STABLE_COUNT))   stable_q <= stable_q + 1'b1;
        end else begin
          stable_q <= '0;
        end
      end
    end
  end

  assign network_output   = net_q;
  assign result_valid     = valid_q;
  assign result_ambiguous = amb_q;
  assign result_stable    = (stable_q == SW'(STABLE_COUNT));
  assign winner_sum       = wsum_q;
  assign seq_error        = seq_err_q;
  assign drop_error       = drop_err_q;
endmodule
